operand2_encoder: RTL and testbench
===================================

Name: operand2_encoder

Overview:
- Multi-cycle encoder that converts a 16-bit constant into the 12-bit rotated-immediate operand2 field: {rot[3:0], imm8[7:0]}.
- The operand2 decode path reconstructs the value as ROR(imm8, 2*rot). This block performs the inverse search.
- Used by the instruction-assembly / self-test path to build MOV/MVN immediates.
- Optionally retries on the bitwise inverse of the value, for MVN encodings.

Parameters:
- TRY_INVERT, 1: when 1, search ~value after the direct search fails; when 0, skip the inverted pass.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- start  input  1  request; sampled only in IDLE.
- value  input  16  constant to encode; latched when start is accepted.
- busy  output  1  high while in SEARCH, SEARCH_INV or DONE.
- done  output  1  one-cycle pulse when the result is valid.
- found  output  1  an encoding exists.
- invert  output  1  the encoding applies to ~value (use MVN).
- operand2  output  12  {rot, imm8}; 12'h000 when found=0.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE.
  - busy=0, done=0, found=0, invert=0, operand2=0.
  - Internal value register and candidate counter cleared.
  - Applies mid-search: the search is abandoned and no done is produced.
- Candidate test, for rot r in 0..7 on a 16-bit word W:
  - Compute C = ROL(W, 2r).
  - Hit when C[15:8]==0. Then imm8=C[7:0] and operand2={r[3:0], C[7:0]}.
  - rot values 8..15 are never produced; they alias 0..7 in 16 bits.
- Candidate index n:
  - n = 0..7 tests W = latched value with r = n.
  - n = 8..15 tests W = ~latched value with r = n-8 (only when TRY_INVERT=1).
- One candidate is evaluated per clock.
- The lowest hitting index wins: smallest rot, direct before inverted.
- FSM:
  - IDLE:
    - start=1 latches value, sets n=0, goes to SEARCH.
    - found, invert and operand2 keep the previous result until this acceptance, then clear to 0.
  - SEARCH, testing n = 0..7:
    - On a hit: found=1, invert=0, operand2 loaded, go to DONE.
    - On a miss with n<7: n=n+1.
    - On a miss with n==7: go to SEARCH_INV with n=8 if TRY_INVERT=1; otherwise found=0, operand2=0, go to DONE.
  - SEARCH_INV, testing n = 8..15:
    - On a hit: found=1, invert=1, operand2 loaded, go to DONE.
    - On a miss with n==15: found=0, invert=0, operand2=0, go to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE.
- Latency:
  - done is high in the cycle following n+2 rising edges after the edge that sampled start, where n is the final candidate index tested.
  - Best case is n=0, 2 edges.
  - Worst case is 17 edges (TRY_INVERT=1) or 9 edges (TRY_INVERT=0).
- Result outputs are stable from the done cycle until the next accepted start.
- start asserted while busy=1, including the DONE cycle, is ignored and not queued. The earliest re-start is the cycle after done.
- value changes after acceptance have no effect on the running search.
- value=0 hits at n=0: operand2=0, found=1.
- All registers update only on the rising edge of clk. There is no combinational path from start or value to any output.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles -> all outputs 0, busy=0; assert start during reset -> no search starts.
- Direct hit, rot 0: value=16'h00AB, start -> done 2 edges later; found=1, invert=0, operand2=12'h0AB.
- Direct hit, nonzero rot: value=16'hC003 -> operand2=12'h10F (rot=1, imm=8'h0F); value=16'hAB00 -> operand2=12'h4AB; check done timing of n+2 edges.
- Inverted hit: value=16'hFFFF, TRY_INVERT=1 -> found=1, invert=1, operand2=12'h000, done at 10 edges. With TRY_INVERT=0 -> found=0, done at 9 edges.
- No encoding: value=16'h0101 -> found=0, invert=0, operand2=0, done at 17 edges. Pulse start at edge 5 -> ignored, result unchanged.
- Reset mid-search: start with 16'h0101, drop reset at edge 6 -> IDLE, no done pulse, outputs 0. A new start with 16'h00FF then gives operand2=12'h0FF.

Source files
------------

// File: rtl/operand2_encoder.sv
// Searches rotations of a 16-bit constant (then of its inverse) for an 8-bit immediate window, one candidate per clock.
// Latency: done pulses n+2 edges after start is sampled (n = final candidate); start is ignored while busy, nothing is queued.
module operand2_encoder #(
    parameter bit TRY_INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        invert,
    output logic [11:0] operand2
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_SEARCH_INV,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_value;
    logic [3:0]  r_n;
    logic        r_busy;
    logic        r_done;
    logic        r_found;
    logic        r_invert;
    logic [11:0] r_operand2;

    logic [15:0] w_word;
    logic [2:0]  w_rot;
    logic [3:0]  w_shift;
    logic [15:0] w_cand;
    logic        w_hit;
    logic        w_last_direct;
    logic        w_last_inv;

    // Candidate index n: bit 3 selects the inverted word, bits 2:0 are the rotation.
    always_comb begin
        w_word        = r_n[3] ? ~r_value : r_value;
        w_rot         = r_n[2:0];
        w_shift       = {w_rot, 1'b0};
        w_cand        = (w_word << w_shift) | (w_word >> (5'd16 - {1'b0, w_shift}));
        w_hit         = (w_cand[15:8] == 8'h00);
        w_last_direct = (r_n == 4'd7);
        w_last_inv    = (r_n == 4'd15);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_value    <= 16'h0000;
            r_n        <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_found    <= 1'b0;
            r_invert   <= 1'b0;
            r_operand2 <= 12'h000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_value    <= value;
                        r_n        <= 4'd0;
                        r_busy     <= 1'b1;
                        r_found    <= 1'b0;
                        r_invert   <= 1'b0;
                        r_operand2 <= 12'h000;
                        r_state    <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_hit) begin
                        r_found    <= 1'b1;
                        r_invert   <= 1'b0;
                        r_operand2 <= {1'b0, w_rot, w_cand[7:0]};
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (w_last_direct) begin
                        if (TRY_INVERT) begin
                            r_n     <= 4'd8;
                            r_state <= S_SEARCH_INV;
                        end else begin
                            r_found    <= 1'b0;
                            r_invert   <= 1'b0;
                            r_operand2 <= 12'h000;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end else begin
                        r_n <= r_n + 4'd1;
                    end
                end
                S_SEARCH_INV: begin
                    if (w_hit) begin
                        r_found    <= 1'b1;
                        r_invert   <= 1'b1;
                        r_operand2 <= {1'b0, w_rot, w_cand[7:0]};
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (w_last_inv) begin
                        r_found    <= 1'b0;
                        r_invert   <= 1'b0;
                        r_operand2 <= 12'h000;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_n <= r_n + 4'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign found    = r_found;
    assign invert   = r_invert;
    assign operand2 = r_operand2;

endmodule

// File: tb/tb_operand2_encoder.sv
// Drives two encoders (inverse retry on / off) with directed and random constants against a rotation-search model.
module tb_operand2_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic        busy_v   [2];
    logic        done_v   [2];
    logic        found_v  [2];
    logic        invert_v [2];
    logic [11:0] op_v     [2];

    int total = 0;
    int bad   = 0;

    // index 0: TRY_INVERT=1, index 1: TRY_INVERT=0
    operand2_encoder #(.TRY_INVERT(1'b1)) u_inv (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]),
        .invert(invert_v[0]), .operand2(op_v[0])
    );

    operand2_encoder #(.TRY_INVERT(1'b0)) u_dir (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]),
        .invert(invert_v[1]), .operand2(op_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Try every even left rotation of v (then of ~v) and keep the first that fits in 8 bits.
    function automatic void model(input logic [15:0] v, input bit inv_en, output bit f,
                                  output bit iv, output logic [11:0] op, output int n);
        f  = 1'b0;
        iv = 1'b0;
        op = 12'h000;
        n  = inv_en ? 15 : 7;
        for (int p = 0; p < (inv_en ? 2 : 1); p++) begin
            for (int r = 0; r < 8; r++) begin
                int w, c;
                w = int'(v);
                if (p == 1) w = w ^ 32'hFFFF;
                c = ((w * (1 << (2 * r))) % 65536) + (w >> (16 - 2 * r));
                if (!f && c < 256) begin
                    f  = 1'b1;
                    iv = (p == 1);
                    op = 12'(r * 256 + c);
                    n  = p * 8 + r;
                end
            end
        end
    endfunction

    task automatic run_op(input logic [15:0] v, input int inj_edge);
        bit          ef [2];
        bit          ei [2];
        logic [11:0] eo [2];
        int          en [2];
        int          seen [2];
        int          pulses [2];
        int          k;
        model(v, 1'b1, ef[0], ei[0], eo[0], en[0]);
        model(v, 1'b0, ef[1], ei[1], eo[1], en[1]);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        for (int d = 0; d < 2; d++) begin
            seen[d] = 0;
            pulses[d] = 0;
            total++;
            if (busy_v[d] !== 1'b1 || done_v[d] !== 1'b0 || found_v[d] !== 1'b0 || op_v[d] !== 12'h000) begin
                bad++;
                $display("FAIL accept_clear dut%0d v=%h: busy=%b done=%b found=%b op=%h, need busy=1 done=0 found=0 op=000",
                         d, v, busy_v[d], done_v[d], found_v[d], op_v[d]);
            end
        end
        while ((seen[0] == 0 || seen[1] == 0) && k < 40) begin
            start = (k + 1 == inj_edge);
            value = 16'($urandom);
            @(negedge clk);
            k++;
            for (int d = 0; d < 2; d++) begin
                if (done_v[d] === 1'b1) begin
                    pulses[d]++;
                    if (seen[d] == 0) seen[d] = k;
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (seen[d] != en[d] + 2 || pulses[d] != 1) begin
                bad++;
                $display("FAIL latency dut%0d v=%h: done at edge %0d (%0d pulses), need edge %0d (1 pulse)",
                         d, v, seen[d], pulses[d], en[d] + 2);
            end
            total++;
            if (found_v[d] !== ef[d] || invert_v[d] !== ei[d] || op_v[d] !== eo[d]) begin
                bad++;
                $display("FAIL result dut%0d v=%h: found=%b invert=%b op=%h, need found=%b invert=%b op=%h",
                         d, v, found_v[d], invert_v[d], op_v[d], ef[d], ei[d], eo[d]);
            end
            total++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
                bad++;
                $display("FAIL idle_after dut%0d v=%h: busy=%b done=%b, need 0 0", d, v, busy_v[d], done_v[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        value = 16'h00AB;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || found_v[d] !== 1'b0 ||
                invert_v[d] !== 1'b0 || op_v[d] !== 12'h000) begin
                bad++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b found=%b invert=%b op=%h, need all 0",
                         d, busy_v[d], done_v[d], found_v[d], invert_v[d], op_v[d]);
            end
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_start dut%0d: busy=%b done=%b, need 0 0", d, busy_v[d], done_v[d]);
            end
        end
    endtask

    task automatic expect_op(input string name, input int d, input bit f, input bit iv, input logic [11:0] op);
        total++;
        if (found_v[d] !== f || invert_v[d] !== iv || op_v[d] !== op) begin
            bad++;
            $display("FAIL %s dut%0d: found=%b invert=%b op=%h, need found=%b invert=%b op=%h",
                     name, d, found_v[d], invert_v[d], op_v[d], f, iv, op);
        end
    endtask

    task automatic test_direct();
        run_op(16'h00AB, 0);
        expect_op("direct_rot0", 0, 1'b1, 1'b0, 12'h0AB);
        run_op(16'hC003, 0);
        expect_op("direct_rot1", 0, 1'b1, 1'b0, 12'h10F);
        run_op(16'hAB00, 0);
        expect_op("direct_rot4", 1, 1'b1, 1'b0, 12'h4AB);
        run_op(16'h0000, 0);
        expect_op("zero_value", 0, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic test_invert();
        run_op(16'hFFFF, 0);
        expect_op("invert_hit", 0, 1'b1, 1'b1, 12'h000);
        expect_op("invert_disabled", 1, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_no_encoding();
        run_op(16'h0101, 5);
        expect_op("no_enc_inv", 0, 1'b0, 1'b0, 12'h000);
        expect_op("no_enc_dir", 1, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        value = 16'h0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (done_v[d] === 1'b1) pulses++;
        end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (busy_v[d] !== 1'b0 || found_v[d] !== 1'b0 || invert_v[d] !== 1'b0 || op_v[d] !== 12'h000) begin
                bad++;
                $display("FAIL mid_reset_state dut%0d: busy=%b found=%b invert=%b op=%h, need all 0",
                         d, busy_v[d], found_v[d], invert_v[d], op_v[d]);
            end
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL mid_reset_done: %0d done pulses during reset, need 0", pulses);
        end
        reset = 1'b1;
        run_op(16'h00FF, 0);
        expect_op("after_reset", 0, 1'b1, 1'b0, 12'h0FF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] v;
            int imm, r, sel;
            sel = $urandom_range(0, 2);
            imm = $urandom_range(0, 255);
            r   = $urandom_range(0, 7);
            v   = 16'((((imm << (16 - 2 * r)) | (imm >> (2 * r))) & 32'hFFFF));
            if (sel == 1) v = ~v;
            if (sel == 2) v = 16'($urandom);
            run_op(v, (i % 5 == 0) ? 3 : 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        value = 16'h0000;
        test_reset();
        test_direct();
        test_invert();
        test_no_encoding();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
